// File: rtl/rank_filter_pipe_pkg.sv
// Shared helpers for the rank filter pipeline: width derivation, pixel slicing
// and the median rank of a window.
package rank_filter_pipe_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int pix_lsb(input int idx, input int dw);
      return idx * dw;
   endfunction

   function automatic int median_rank(input int n);
      return n / 2;
   endfunction

   localparam int DEF_ELEMENT_NUM = 25;
   localparam int DEF_DATA_WIDTH  = 8;

endpackage

// File: rtl/rank_count.sv
// Rank of one window element: how many elements sort strictly before it,
// with equal values ordered by index so every rank is unique.
module rank_count
   import rank_filter_pipe_pkg::*;
#(
   parameter int ELEMENT_NUM = DEF_ELEMENT_NUM,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int RANK_W      = clog2(DEF_ELEMENT_NUM)
) (
   input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] pixels_i,
   input  logic [RANK_W-1:0]                 idx_i,
   output logic [RANK_W:0]                   rank_o
);

   localparam logic [RANK_W:0] ONE = (RANK_W+1)'(1);

   logic [DATA_WIDTH-1:0] own;
   logic [DATA_WIDTH-1:0] pj;
   logic [RANK_W:0]       cnt;

   always_comb begin
      own = pixels_i[pix_lsb(int'(idx_i), DATA_WIDTH) +: DATA_WIDTH];
      pj  = '0;
      cnt = '0;
      for (int j = 0; j < ELEMENT_NUM; j++) begin
         pj = pixels_i[pix_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
         if ((pj < own) || ((pj == own) && (RANK_W'(j) < idx_i)))
            cnt = cnt + ONE;
      end
   end

   assign rank_o = cnt;

endmodule

// File: rtl/rank_filter_pipe.sv
// Three-stage handshaked k-th-smallest selector: capture, per-element rank
// count, one-hot select. Any stage advances when empty or when its successor advances.
module rank_filter_pipe
   import rank_filter_pipe_pkg::*;
#(
   parameter  int ELEMENT_NUM = DEF_ELEMENT_NUM,
   parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
   localparam int RANK_W      = clog2(ELEMENT_NUM)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] pixels,
   input  logic [RANK_W-1:0]                 rank,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             result,
   output logic                              rank_err
);

   localparam int              PW       = ELEMENT_NUM * DATA_WIDTH;
   localparam logic [RANK_W-1:0] MAX_RANK = RANK_W'(ELEMENT_NUM - 1);

   logic                 s0_valid_q, s1_valid_q, s2_valid_q;
   logic [PW-1:0]        s0_pix_q, s1_pix_q;
   logic [RANK_W-1:0]    s0_rank_q, s1_rank_q;
   logic                 s0_err_q, s1_err_q, s2_err_q;
   logic [ELEMENT_NUM-1:0][RANK_W:0] s1_r_q;
   logic [DATA_WIDTH-1:0] s2_result_q;

   logic [RANK_W-1:0]    rank_c_d;
   logic                 err_d;
   logic [ELEMENT_NUM-1:0][RANK_W:0] r_d;
   logic [DATA_WIDTH-1:0] result_d;
   logic                 s0_load, s1_load, s2_load;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign s0_load  = !s0_valid_q || s1_load;
   assign in_ready = s0_load && !rst;

   // Out-of-range ranks are clamped to the maximum and flagged.
   assign err_d    = rank > MAX_RANK;
   assign rank_c_d = err_d ? MAX_RANK : rank;

   for (genvar i = 0; i < ELEMENT_NUM; i++) begin : g_rank
      rank_count #(
         .ELEMENT_NUM (ELEMENT_NUM),
         .DATA_WIDTH  (DATA_WIDTH),
         .RANK_W      (RANK_W)
      ) u_rank_count (
         .pixels_i (s0_pix_q),
         .idx_i    (RANK_W'(i)),
         .rank_o   (r_d[i])
      );
   end

   // Ranks form a permutation, so exactly one element matches and an OR mux suffices.
   always_comb begin
      result_d = '0;
      for (int i = 0; i < ELEMENT_NUM; i++) begin
         if (s1_r_q[i] == {1'b0, s1_rank_q})
            result_d = result_d | s1_pix_q[pix_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_q  <= 1'b0;
         s0_pix_q    <= '0;
         s0_rank_q   <= '0;
         s0_err_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_pix_q    <= '0;
         s1_rank_q   <= '0;
         s1_err_q    <= 1'b0;
         s1_r_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_err_q    <= 1'b0;
      end else begin
         if (s0_load) begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
               s0_pix_q  <= pixels;
               s0_rank_q <= rank_c_d;
               s0_err_q  <= err_d;
            end
         end
         if (s1_load) begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
               s1_pix_q  <= s0_pix_q;
               s1_rank_q <= s0_rank_q;
               s1_err_q  <= s0_err_q;
               s1_r_q    <= r_d;
            end
         end
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_result_q <= result_d;
               s2_err_q    <= s1_err_q;
            end
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = s2_result_q;
   assign rank_err  = s2_err_q;

endmodule

// File: tb/tb_rank_filter_pipe.sv
// Directed and random stimulus for rank_filter_pipe, scored against a
// sort-based reference model with an in-order expectation queue.
module tb_rank_filter_pipe;
   import rank_filter_pipe_pkg::*;

   localparam int N  = 25;
   localparam int DW = 8;
   localparam int RW = clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] pixels;
   logic [RW-1:0]   rank;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   result;
   logic            rank_err;

   always #5 clk = ~clk;

   rank_filter_pipe #(.ELEMENT_NUM(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pixels    (pixels),
      .rank      (rank),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rank_err  (rank_err)
   );

   typedef struct packed {
      logic [DW-1:0] res;
      logic          err;
   } exp_t;

   exp_t  sb[$];
   int    deliv_cyc[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   bit    acc_last = 0;
   bit    hold_valid = 0;
   logic [DW-1:0] hold_res;
   logic          hold_err;

   int W[N] = '{195,77,97,162,132,119,97,162,156,32,131,94,30,72,143,77,237,80,52,236,56,215,95,124,187};

   function automatic logic [N*DW-1:0] w_vec();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(W[i]);
      return v;
   endfunction

   // k-th smallest by sorting; out-of-range ranks pick the maximum.
   function automatic exp_t model(input logic [N*DW-1:0] p, input int rk);
      int   q[$];
      int   idx;
      exp_t e;
      for (int i = 0; i < N; i++) q.push_back(int'(p[i*DW +: DW]));
      q.sort();
      idx   = (rk >= N) ? N - 1 : rk;
      e.res = DW'(q[idx]);
      e.err = (rk >= N);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the negedge drive, score handshakes, advance.
   task automatic tick();
      exp_t e;
      #1;
      if (hold_valid) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(hold_res));
         check("hold_err", 32'(rank_err), 32'(hold_err));
      end
      if (rst) check("rst_in_ready", 32'(in_ready), 32'd0);
      acc_last = in_valid && in_ready;
      if (acc_last) begin
         sb.push_back(model(pixels, int'(rank)));
         acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
         deliv_cyc.push_back(cyc);
         vectors++;
         assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_output observed=%0d expected=none", result);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("rank_err", 32'(rank_err), 32'(e.err));
         end
      end
      hold_valid = out_valid && !out_ready && !rst;
      hold_res   = result;
      hold_err   = rank_err;
      if (rst) sb.delete();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget && sb.size() > 0; i++) tick();
      check("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   task automatic rand_pixels(input int lim);
      for (int i = 0; i < N; i++) pixels[i*DW +: DW] = DW'($urandom_range(0, lim));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      int cnt;
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pixels = '0; rank = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_rank_err", 32'(rank_err), 32'd0);
      check("post_reset_in_ready", 32'(in_ready), 32'd1);

      // T1: median of W, latency 3 cycles from accept cycle
      deliv_cyc.delete();
      out_ready = 1'b1; in_valid = 1'b1; pixels = w_vec(); rank = RW'(median_rank(N));
      tick();
      check("t1_accept", 32'(acc_last), 32'd1);
      drain(20);
      check("t1_delivered", 32'(deliv_cyc.size()), 32'd1);
      lat = (deliv_cyc.size() > 0) ? deliv_cyc[0] - acc_cyc : -1;
      check("t1_latency", 32'(lat), 32'd3);

      // T2: back-to-back ranks, one result per cycle
      deliv_cyc.delete();
      in_valid = 1'b1; pixels = w_vec();
      foreach (W[i]) begin
         if (i == 0) rank = 0; else if (i == 1) rank = 5; else if (i == 2) rank = 6; else if (i == 3) rank = 24;
         if (i < 4) begin
            tick();
            check("t2_accept", 32'(acc_last), 32'd1);
         end
      end
      drain(20);
      check("t2_count", 32'(deliv_cyc.size()), 32'd4);
      lat = (deliv_cyc.size() == 4) ? deliv_cyc[3] - deliv_cyc[0] : -1;
      check("t2_span", 32'(lat), 32'd3);

      // T3: all-equal window, full rank sweep
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) pixels[i*DW +: DW] = 8'hAA;
      for (int r = 0; r < N; r++) begin
         rank = RW'(r);
         tick();
      end
      drain(40);

      // T4: out-of-range ranks clamp to max
      in_valid = 1'b1; pixels = w_vec();
      rank = RW'(25); tick();
      rank = RW'(31); tick();
      drain(20);

      // T5: downstream stall with input held valid
      out_ready = 1'b0; in_valid = 1'b1; pixels = w_vec(); rank = '0; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (acc_last) begin
            cnt++;
            rank = rank + 1'b1;
         end
      end
      check("t5_accepts", 32'(cnt), 32'd3);
      #1;
      check("t5_in_ready_full", 32'(in_ready), 32'd0);
      check("t5_out_valid", 32'(out_valid), 32'd1);
      check("t5_held_result", 32'(result), 32'd30);
      out_ready = 1'b1;
      #1;
      check("t5_in_ready_release", 32'(in_ready), 32'd1);
      for (int i = 0; i < 10 && in_valid; i++) begin
         tick();
         if (acc_last) begin
            if (rank == RW'(3)) in_valid = 1'b0;
            else rank = rank + 1'b1;
         end
      end
      check("t5_all_accepted", 32'(in_valid), 32'd0);
      drain(20);

      // T6: reset with two windows in flight
      deliv_cyc.delete();
      out_ready = 1'b1; in_valid = 1'b1; pixels = w_vec(); rank = '0;
      tick();
      rand_pixels(255); rank = RW'(24);
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_result", 32'(result), 32'd0);
      check("t6_rank_err", 32'(rank_err), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      check("t6_no_emission", 32'(deliv_cyc.size()), 32'd0);
      in_valid = 1'b1; rand_pixels(255); rank = RW'(7);
      tick();
      check("t6_new_accept", 32'(acc_last), 32'd1);
      drain(20);

      // Random traffic with ties and random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rand_pixels(($urandom_range(0, 1) == 0) ? 7 : 255);
         rank = RW'($urandom_range(0, 31));
         tick();
      end
      drain(50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
